// File: rtl/tlul_pkg.sv
// TL-UL bundle types and opcodes shared by the error gate and its checker.
// Ports: none (package only).
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Opcode fields are plain vectors so illegal encodings can be carried.
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_err.sv
// A-channel legality check for a 32-bit TL-UL bus.
// Ports: tl_i (host request, A fields examined), err_o (1 = illegal request).
module tlul_err
  import tlul_pkg::*;
(
  input  tl_h2d_t tl_i,
  output logic    err_o
);

  logic       op_ok;
  logic       addr_ok;
  logic       mask_ok;
  logic       full_ok;
  logic [3:0] lanes;

  always_comb begin
    op_ok   = (tl_i.a_opcode == Get)
            | (tl_i.a_opcode == PutFullData)
            | (tl_i.a_opcode == PutPartialData);
    addr_ok = 1'b0;
    lanes   = 4'h0;
    unique case (tl_i.a_size)
      2'd0: begin
        addr_ok = 1'b1;
        lanes   = 4'b0001 << tl_i.a_address[1:0];
      end
      2'd1: begin
        addr_ok = ~tl_i.a_address[0];
        lanes   = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        addr_ok = (tl_i.a_address[1:0] == 2'b00);
        lanes   = 4'hF;
      end
      default: begin
        addr_ok = 1'b0;
        lanes   = 4'h0;
      end
    endcase
    // Byte enables must stay inside the addressed lanes;
    // a full write must enable every one of them.
    mask_ok = ((tl_i.a_mask & ~lanes) == 4'h0);
    full_ok = (tl_i.a_opcode != PutFullData)
            | (tl_i.a_mask == lanes);
    err_o   = ~(op_ok & addr_ok & mask_ok & full_ok);
  end

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_valid, tl_i.a_param,
                       tl_i.a_source, tl_i.a_data,
                       tl_i.d_ready};

endmodule

// File: rtl/tlul_err_gate.sv
// Screens TL-UL A requests; forwards legal ones, answers illegal ones locally
// with d_error=1, keeping responses in request order.
// Ports: clk_i, rst_i (sync, active-high), tl_h_i/tl_h_o (host side),
//        tl_d_o/tl_d_i (device side), err_cnt_o (only with TLUL_ERR_GATE_CNT_EN).
module tlul_err_gate
  import tlul_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [31:0] ErrRspData     = 32'hFFFF_FFFF
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h_i,
  output tl_d2h_t tl_h_o,
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i
`ifdef TLUL_ERR_GATE_CNT_EN
  ,
  output logic [15:0] err_cnt_o
`endif
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    Pass,
    ErrWait,
    ErrRsp
  } gate_state_e;

  gate_state_e     state_q;
  gate_state_e     state_d;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      src_q;
  logic [1:0]      size_q;
  logic [2:0]      op_q;

  logic err;
  logic bad;
  logic idle;
  logic full;
  logic accept_err;
  logic fwd_hs;
  logic dev_d_hs;

  tlul_err u_err (
    .tl_i  (tl_h_i),
    .err_o (err)
  );

  assign bad  = tl_h_i.a_valid & err;
  assign idle = (cnt_q == '0);
  assign full = (cnt_q == CntW'(MaxOutstanding));

  always_comb begin
    state_d        = state_q;
    accept_err     = 1'b0;
    tl_d_o         = tl_h_i;
    tl_h_o         = tl_d_i;
    tl_h_o.a_ready = 1'b0;
    unique case (state_q)
      Pass: begin
        if (bad) begin
          tl_d_o.a_valid = 1'b0;
          if (idle) begin
            accept_err     = 1'b1;
            tl_h_o.a_ready = 1'b1;
            state_d        = ErrRsp;
          end else begin
            state_d = ErrWait;
          end
        end else if (full) begin
          tl_d_o.a_valid = 1'b0;
        end else begin
          tl_h_o.a_ready = tl_d_i.a_ready;
        end
      end
      ErrWait: begin
        // Hold the bad request until every forwarded one has answered.
        tl_d_o.a_valid = 1'b0;
        if (!bad) begin
          state_d = Pass;
        end else if (idle) begin
          accept_err     = 1'b1;
          tl_h_o.a_ready = 1'b1;
          state_d        = ErrRsp;
        end
      end
      ErrRsp: begin
        tl_d_o.a_valid  = 1'b0;
        tl_d_o.d_ready  = 1'b0;
        tl_h_o.d_valid  = 1'b1;
        tl_h_o.d_opcode = (op_q == Get) ? AccessAckData : AccessAck;
        tl_h_o.d_param  = 3'h0;
        tl_h_o.d_size   = size_q;
        tl_h_o.d_source = src_q;
        tl_h_o.d_sink   = 1'b0;
        tl_h_o.d_data   = (op_q == Get) ? ErrRspData : 32'h0;
        tl_h_o.d_error  = 1'b1;
        if (tl_h_i.d_ready) begin
          state_d = Pass;
        end
      end
      default: begin
        state_d = Pass;
      end
    endcase
    if (rst_i) begin
      tl_h_o.d_valid = 1'b0;
      tl_h_o.a_ready = 1'b0;
      tl_d_o.a_valid = 1'b0;
      accept_err     = 1'b0;
    end
  end

  assign fwd_hs   = tl_d_o.a_valid & tl_d_i.a_ready;
  assign dev_d_hs = tl_d_i.d_valid & tl_d_o.d_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Pass;
      cnt_q   <= '0;
      src_q   <= '0;
      size_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (fwd_hs && !dev_d_hs) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (!fwd_hs && dev_d_hs) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      if (accept_err) begin
        src_q  <= tl_h_i.a_source;
        size_q <= tl_h_i.a_size;
        op_q   <= tl_h_i.a_opcode;
      end
    end
  end

`ifdef TLUL_ERR_GATE_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (accept_err && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_tlul_err_gate.sv
// Testbench for tlul_err_gate: directed scenarios plus randomized traffic
// against a transaction-level host/device reference model.
module tb_tlul_err_gate;
  import tlul_pkg::*;

  logic    clk;
  logic    rst_i;
  tl_h2d_t tl_h_i;
  tl_d2h_t tl_h_o;
  tl_h2d_t tl_d_o;
  tl_d2h_t tl_d_i;
`ifdef TLUL_ERR_GATE_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  int vectors;
  int miscompares;
  int err_model;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  tlul_err_gate dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .tl_h_i (tl_h_i),
    .tl_h_o (tl_h_o),
    .tl_d_o (tl_d_o),
    .tl_d_i (tl_d_i)
`ifdef TLUL_ERR_GATE_CNT_EN
    ,
    .err_cnt_o (err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit ref_legal(tl_h2d_t r);
    int bytes;
    int off;
    int lanes;
    if (!(r.a_opcode inside {3'h0, 3'h1, 3'h4})) return 1'b0;
    if (r.a_size == 2'd3) return 1'b0;
    bytes = 1 << r.a_size;
    off   = int'(r.a_address[1:0]);
    if (off % bytes != 0) return 1'b0;
    lanes = ((1 << bytes) - 1) << off;
    if ((int'(r.a_mask) & ~lanes & 15) != 0) return 1'b0;
    if (r.a_opcode == 3'h0 && int'(r.a_mask) != lanes) return 1'b0;
    return 1'b1;
  endfunction

  // Device model: Get returns address-derived data, writes return nothing.
  function automatic rsp_t dev_rsp(tl_h2d_t r);
    rsp_t x;
    x.op   = (r.a_opcode == 3'h4) ? 3'h1 : 3'h0;
    x.size = r.a_size;
    x.src  = r.a_source;
    x.data = (r.a_opcode == 3'h4) ? (r.a_address ^ 32'hC0DE_0000) : 32'h0;
    x.err  = 1'b0;
    return x;
  endfunction

  function automatic rsp_t err_rsp(tl_h2d_t r);
    rsp_t x;
    x.op   = (r.a_opcode == 3'h4) ? 3'h1 : 3'h0;
    x.size = r.a_size;
    x.src  = r.a_source;
    x.data = (r.a_opcode == 3'h4) ? 32'hFFFF_FFFF : 32'h0;
    x.err  = 1'b1;
    return x;
  endfunction

  task automatic drive_idle();
    tl_h_i         = '0;
    tl_h_i.d_ready = 1'b1;
    tl_d_i         = '0;
    tl_d_i.a_ready = 1'b1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [3:0] mask,
                         input logic [7:0] src);
    tl_h_i.a_valid   = 1'b1;
    tl_h_i.a_opcode  = op;
    tl_h_i.a_param   = 3'h0;
    tl_h_i.a_size    = sz;
    tl_h_i.a_address = addr;
    tl_h_i.a_mask    = mask;
    tl_h_i.a_data    = 32'hA5A5_0000 | addr;
    tl_h_i.a_source  = src;
  endtask

  task automatic set_dev_rsp(input logic [7:0] src, input logic [31:0] data);
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_opcode = 3'h1;
    tl_d_i.d_param  = 3'h0;
    tl_d_i.d_size   = 2'd2;
    tl_d_i.d_source = src;
    tl_d_i.d_sink   = 1'b0;
    tl_d_i.d_data   = data;
    tl_d_i.d_error  = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive_idle();
    set_req(3'h4, 2'd2, 32'h10, 4'hF, 8'h1);
    set_dev_rsp(8'h1, 32'h1);
    @(negedge clk);
    #1;
    vectors++;
    if ({tl_h_o.d_valid, tl_h_o.a_ready, tl_d_o.a_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_out: dv/ar/fav=%b want 000",
               {tl_h_o.d_valid, tl_h_o.a_ready, tl_d_o.a_valid});
    end
    @(negedge clk);
    rst_i = 1'b0;
    drive_idle();
    err_model = 0;
`ifdef TLUL_ERR_GATE_CNT_EN
    #1;
    vectors++;
    if (err_cnt_o !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %h want 0", err_cnt_o);
    end
`endif
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    set_req(3'h4, 2'd2, 32'h10, 4'hF, 8'h3);
    #1;
    vectors++;
    if (tl_d_o !== tl_h_i || tl_h_o.a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pass_fwd: d_o=%h ar=%b want %h 1",
               tl_d_o, tl_h_o.a_ready, tl_h_i);
    end
    @(negedge clk);
    tl_h_i.a_valid = 1'b0;
    set_dev_rsp(8'h3, 32'h1234_5678);
    #1;
    vectors++;
    if ({tl_h_o.d_valid, tl_h_o.d_opcode, tl_h_o.d_source,
         tl_h_o.d_data, tl_h_o.d_error}
        !== {1'b1, 3'h1, 8'h3, 32'h1234_5678, 1'b0}) begin
      miscompares++;
      $display("FAIL pass_rsp: dv=%b op=%h src=%h data=%h e=%b want 1 1 03 12345678 0",
               tl_h_o.d_valid, tl_h_o.d_opcode, tl_h_o.d_source,
               tl_h_o.d_data, tl_h_o.d_error);
    end
    @(negedge clk);
    drive_idle();
  endtask

  // One illegal request at cnt 0: accepted at once, answered next cycle.
  task automatic test_err_case(input string nm, input logic [2:0] op,
                               input logic [1:0] sz, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [7:0] src,
                               input logic [2:0] xop, input logic [31:0] xdata);
    @(negedge clk);
    set_req(op, sz, addr, mask, src);
    #1;
    vectors++;
    if ({tl_d_o.a_valid, tl_h_o.a_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s_accept: fav/ar=%b want 01", nm,
               {tl_d_o.a_valid, tl_h_o.a_ready});
    end
    err_model++;
    @(negedge clk);
    tl_h_i.a_valid = 1'b0;
    #1;
    vectors++;
    if ({tl_h_o.d_valid, tl_h_o.d_opcode, tl_h_o.d_error, tl_h_o.d_source,
         tl_h_o.d_size, tl_h_o.d_data, tl_h_o.d_sink, tl_h_o.d_param}
        !== {1'b1, xop, 1'b1, src, sz, xdata, 1'b0, 3'h0}) begin
      miscompares++;
      $display("FAIL %s_rsp: dv=%b op=%h e=%b src=%h sz=%h data=%h want op %h data %h",
               nm, tl_h_o.d_valid, tl_h_o.d_opcode, tl_h_o.d_error,
               tl_h_o.d_source, tl_h_o.d_size, tl_h_o.d_data, xop, xdata);
    end
`ifdef TLUL_ERR_GATE_CNT_EN
    vectors++;
    if (err_cnt_o !== 16'(err_model)) begin
      miscompares++;
      $display("FAIL %s_cnt: got %0d want %0d", nm, err_cnt_o, err_model);
    end
`endif
    @(negedge clk);
    #1;
    vectors++;
    if (tl_h_o.d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: dv=%b want 0", nm, tl_h_o.d_valid);
    end
  endtask

  task automatic test_ordering();
    @(negedge clk);
    set_req(3'h4, 2'd2, 32'h20, 4'hF, 8'h1);
    #1;
    vectors++;
    if (tl_h_o.a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ord_g1: ar=%b want 1", tl_h_o.a_ready);
    end
    @(negedge clk);
    set_req(3'h4, 2'd2, 32'h24, 4'hF, 8'h2);
    #1;
    vectors++;
    if (tl_h_o.a_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ord_g2: ar=%b want 1", tl_h_o.a_ready);
    end
    @(negedge clk);
    set_req(3'h0, 2'd1, 32'h21, 4'h3, 8'h7);
    repeat (3) begin
      #1;
      vectors++;
      if ({tl_h_o.a_ready, tl_d_o.a_valid, tl_h_o.d_valid} !== 3'b000) begin
        miscompares++;
        $display("FAIL ord_hold: ar/fav/dv=%b want 000",
                 {tl_h_o.a_ready, tl_d_o.a_valid, tl_h_o.d_valid});
      end
      @(negedge clk);
    end
    set_dev_rsp(8'h1, 32'h0000_0020);
    #1;
    vectors++;
    if ({tl_h_o.d_valid, tl_h_o.d_source, tl_h_o.a_ready} !== {1'b1, 8'h1, 1'b0}) begin
      miscompares++;
      $display("FAIL ord_r1: dv=%b src=%h ar=%b want 1 01 0",
               tl_h_o.d_valid, tl_h_o.d_source, tl_h_o.a_ready);
    end
    @(negedge clk);
    set_dev_rsp(8'h2, 32'h0000_0024);
    #1;
    vectors++;
    if ({tl_h_o.d_valid, tl_h_o.d_source, tl_h_o.a_ready} !== {1'b1, 8'h2, 1'b0}) begin
      miscompares++;
      $display("FAIL ord_r2: dv=%b src=%h ar=%b want 1 02 0",
               tl_h_o.d_valid, tl_h_o.d_source, tl_h_o.a_ready);
    end
    @(negedge clk);
    tl_d_i.d_valid = 1'b0;
    #1;
    vectors++;
    if ({tl_h_o.a_ready, tl_d_o.a_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL ord_accept: ar/fav=%b want 10", {tl_h_o.a_ready, tl_d_o.a_valid});
    end
    err_model++;
    @(negedge clk);
    tl_h_i.a_valid = 1'b0;
    #1;
    vectors++;
    if ({tl_h_o.d_valid, tl_h_o.d_error, tl_h_o.d_source, tl_h_o.d_opcode}
        !== {1'b1, 1'b1, 8'h7, 3'h0}) begin
      miscompares++;
      $display("FAIL ord_err: dv=%b e=%b src=%h op=%h want 1 1 07 0",
               tl_h_o.d_valid, tl_h_o.d_error, tl_h_o.d_source, tl_h_o.d_opcode);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_req(3'h4, 2'd2, 32'h40 + 32'(4 * i), 4'hF, 8'(i));
      #1;
      vectors++;
      if (tl_h_o.a_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL full_fill%0d: ar=%b want 1", i, tl_h_o.a_ready);
      end
    end
    @(negedge clk);
    set_req(3'h4, 2'd2, 32'h50, 4'hF, 8'h9);
    repeat (2) begin
      #1;
      vectors++;
      if ({tl_h_o.a_ready, tl_d_o.a_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL full_hold: ar/fav=%b want 00", {tl_h_o.a_ready, tl_d_o.a_valid});
      end
      @(negedge clk);
    end
    set_dev_rsp(8'h0, 32'h40);
    #1;
    vectors++;
    if (tl_h_o.a_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_drain: ar=%b want 0", tl_h_o.a_ready);
    end
    @(negedge clk);
    tl_d_i.d_valid = 1'b0;
    #1;
    vectors++;
    if ({tl_h_o.a_ready, tl_d_o.a_valid} !== 2'b11) begin
      miscompares++;
      $display("FAIL full_go: ar/fav=%b want 11", {tl_h_o.a_ready, tl_d_o.a_valid});
    end
    @(negedge clk);
    tl_h_i.a_valid = 1'b0;
    set_dev_rsp(8'h1, 32'h44);
    repeat (4) @(negedge clk);
    drive_idle();
  endtask

  task automatic test_backpressure_reset();
    @(negedge clk);
    set_req(3'h4, 2'd3, 32'h0, 4'hF, 8'h5A);
    tl_h_i.d_ready = 1'b0;
    err_model++;
    @(negedge clk);
    tl_h_i.a_valid = 1'b0;
    repeat (5) begin
      #1;
      vectors++;
      if ({tl_h_o.d_valid, tl_h_o.d_opcode, tl_h_o.d_error, tl_h_o.d_source,
           tl_h_o.d_size, tl_h_o.d_data, tl_h_o.a_ready, tl_d_o.d_ready}
          !== {1'b1, 3'h1, 1'b1, 8'h5A, 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold: dv=%b op=%h e=%b src=%h sz=%h data=%h ar=%b ddr=%b",
                 tl_h_o.d_valid, tl_h_o.d_opcode, tl_h_o.d_error, tl_h_o.d_source,
                 tl_h_o.d_size, tl_h_o.d_data, tl_h_o.a_ready, tl_d_o.d_ready);
      end
      @(negedge clk);
    end
    rst_i = 1'b1;
    #1;
    vectors++;
    if (tl_h_o.d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_gate: dv=%b want 0", tl_h_o.d_valid);
    end
    @(negedge clk);
    rst_i = 1'b0;
    err_model = 0;
    #1;
    vectors++;
    if (tl_h_o.d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_drop: dv=%b want 0", tl_h_o.d_valid);
    end
`ifdef TLUL_ERR_GATE_CNT_EN
    vectors++;
    if (err_cnt_o !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_cnt: got %h want 0", err_cnt_o);
    end
`endif
    drive_idle();
    test_err_case("post_rst", 3'h1, 2'd2, 32'h3, 4'hF, 8'h11, 3'h0, 32'h0);
  endtask

  task automatic test_random();
    tl_h2d_t req;
    rsp_t    exp_q[$];
    rsp_t    dev_q[$];
    rsp_t    got;
    bit      busy;
    bit      dev_dv;
    bit      h_a_hs;
    bit      d_a_hs;
    bit      h_d_hs;
    bit      d_d_hs;
    int      cyc;
    busy   = 1'b0;
    dev_dv = 1'b0;
    req    = '0;
    cyc    = 0;
    while (cyc < 3000 || busy || exp_q.size() != 0) begin
      if (cyc > 3400) begin
        vectors++;
        miscompares++;
        $display("FAIL rnd_drain: %0d responses still owed", exp_q.size());
        break;
      end
      @(negedge clk);
      if (!busy && cyc < 3000 && ($urandom % 2) == 0) begin
        req = '0;
        req.a_valid = 1'b1;
        case ($urandom % 8)
          0:       req.a_opcode = 3'($urandom);
          1, 2, 3: req.a_opcode = 3'h4;
          4, 5:    req.a_opcode = 3'h0;
          default: req.a_opcode = 3'h1;
        endcase
        req.a_size    = (($urandom % 6) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        req.a_address = $urandom;
        req.a_source  = 8'($urandom);
        req.a_data    = $urandom;
        if (($urandom % 3) != 0) begin
          if (req.a_size == 2'd1) req.a_address[0] = 1'b0;
          if (req.a_size >= 2'd2) req.a_address[1:0] = 2'b00;
        end
        if (($urandom % 3) != 0) begin
          case (req.a_size)
            2'd0:    req.a_mask = 4'b0001 << req.a_address[1:0];
            2'd1:    req.a_mask = req.a_address[1] ? 4'b1100 : 4'b0011;
            default: req.a_mask = 4'hF;
          endcase
        end else begin
          req.a_mask = 4'($urandom);
        end
        busy = 1'b1;
      end
      tl_h_i         = busy ? req : '0;
      tl_h_i.d_ready = (cyc >= 3000) || (($urandom % 4) != 0);
      tl_d_i         = '0;
      tl_d_i.a_ready = ($urandom % 4) != 0;
      if (!dev_dv && dev_q.size() != 0 && ($urandom % 3) == 0) dev_dv = 1'b1;
      if (dev_dv) begin
        tl_d_i.d_valid  = 1'b1;
        tl_d_i.d_opcode = dev_q[0].op;
        tl_d_i.d_size   = dev_q[0].size;
        tl_d_i.d_source = dev_q[0].src;
        tl_d_i.d_data   = dev_q[0].data;
        tl_d_i.d_error  = dev_q[0].err;
      end
      #1;
      h_a_hs = tl_h_i.a_valid & tl_h_o.a_ready;
      d_a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
      h_d_hs = tl_h_o.d_valid & tl_h_i.d_ready;
      d_d_hs = tl_d_i.d_valid & tl_d_o.d_ready;
      if (d_a_hs) begin
        vectors++;
        if (!ref_legal(tl_h_i) || !h_a_hs || tl_d_o !== tl_h_i) begin
          miscompares++;
          $display("FAIL rnd_fwd: fwd=%h host=%h legal=%0d hs=%0d",
                   tl_d_o, tl_h_i, ref_legal(tl_h_i), h_a_hs);
        end
        dev_q.push_back(dev_rsp(tl_d_o));
        vectors++;
        if (dev_q.size() > 4) begin
          miscompares++;
          $display("FAIL rnd_outstanding: got %0d want <=4", dev_q.size());
        end
      end
      if (h_a_hs) begin
        if (ref_legal(tl_h_i)) begin
          exp_q.push_back(dev_rsp(tl_h_i));
        end else begin
          vectors++;
          if (tl_d_o.a_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rnd_block: fav=%b want 0", tl_d_o.a_valid);
          end
          exp_q.push_back(err_rsp(tl_h_i));
          err_model++;
        end
        busy = 1'b0;
      end
      if (h_d_hs) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_rsp: unexpected response src=%h want none", tl_h_o.d_source);
        end else begin
          got = exp_q.pop_front();
          if ({tl_h_o.d_opcode, tl_h_o.d_size, tl_h_o.d_source,
               tl_h_o.d_data, tl_h_o.d_error, tl_h_o.d_param}
              !== {got.op, got.size, got.src, got.data, got.err, 3'h0}) begin
            miscompares++;
            $display("FAIL rnd_rsp: op=%h sz=%h src=%h data=%h e=%b want %h %h %h %h %b",
                     tl_h_o.d_opcode, tl_h_o.d_size, tl_h_o.d_source,
                     tl_h_o.d_data, tl_h_o.d_error,
                     got.op, got.size, got.src, got.data, got.err);
          end
        end
      end
      if (d_d_hs) begin
        void'(dev_q.pop_front());
        dev_dv = 1'b0;
      end
      cyc++;
    end
`ifdef TLUL_ERR_GATE_CNT_EN
    vectors++;
    if (err_cnt_o !== 16'(err_model)) begin
      miscompares++;
      $display("FAIL rnd_cnt: got %0d want %0d", err_cnt_o, err_model);
    end
`endif
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    err_model   = 0;
    rst_i       = 1'b1;
    drive_idle();
    test_reset();
    test_pass_through();
    test_err_case("misalign", 3'h0, 2'd2, 32'h2, 4'hF, 8'h21, 3'h0, 32'h0);
    test_err_case("bad_op", 3'h5, 2'd2, 32'h0, 4'hF, 8'h22, 3'h0, 32'h0);
    test_err_case("get_sz3", 3'h4, 2'd3, 32'h0, 4'hF, 8'h23, 3'h1, 32'hFFFF_FFFF);
    test_ordering();
    test_full();
    test_backpressure_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
